// File: rtl/bus_pkg.sv
// Shared encodings for the 8085 bus cycle controller: request types, FSM states, s1/s0 status codes.
// ST_TW exists only when WAIT_STATE_EN is defined.
package bus_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_RSVD  = 2'b11
  } req_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
`ifdef WAIT_STATE_EN
    ST_TW   = 3'd3,
`endif
    ST_T3   = 3'd4
  } state_e;

  localparam logic [1:0] STAT_IDLE  = 2'b00;
  localparam logic [1:0] STAT_WRITE = 2'b01;
  localparam logic [1:0] STAT_READ  = 2'b10;
  localparam logic [1:0] STAT_FETCH = 2'b11;

  function automatic logic [1:0] status_of(input req_type_e t);
    logic [1:0] s;
    case (t)
      REQ_FETCH: s = STAT_FETCH;
      REQ_READ:  s = STAT_READ;
      REQ_WRITE: s = STAT_WRITE;
      default:   s = STAT_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// 8085-style T1/T2/(TW)/T3 bus cycle controller driving a 32x8 RAM stage.
// Define WAIT_STATE_EN to honour READY and compile the TW wait state.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [1:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ack,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  input  logic                  ready,
  output logic                  ale,
  output logic                  s1,
  output logic                  s0,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_e                  state_q, state_d;
  req_type_e               type_q, type_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    req_ack_q, req_ack_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    ale_q, ale_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [1:0]              stat_q, stat_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

`ifndef WAIT_STATE_EN
  logic unused_ready_s;
  assign unused_ready_s = ready;
`endif

  // Next-state logic: request acceptance, cycle sequencing and read-data capture
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ack_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && (req_type != REQ_RSVD)) begin
          state_d   = ST_T1;
          type_d    = req_type_e'(req_type);
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          req_ack_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: state_d = ST_T2;
`ifdef WAIT_STATE_EN
      ST_T2: begin
        if (ready) begin
          state_d = ST_T3;
        end else begin
          state_d = ST_TW;
        end
      end
      ST_TW: begin
        if (ready) begin
          state_d = ST_T3;
        end else begin
          state_d = ST_TW;
        end
      end
`else
      ST_T2: state_d = ST_T3;
`endif
      ST_T3: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        // rdata keeps the last read value across writes
        if (type_q != REQ_WRITE) begin
          rdata_d = mem_data;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they can be registered without lag
  always_comb begin
    ale_d    = 1'b0;
    mem_en_d = 1'b0;
    if (state_d != ST_IDLE) begin
      busy_d     = 1'b1;
      stat_d     = status_of(type_d);
      mem_addr_d = addr_d;
    end else begin
      busy_d     = 1'b0;
      stat_d     = STAT_IDLE;
      mem_addr_d = {ADDR_WIDTH{1'b0}};
    end
    case (state_d)
      ST_T1: ale_d    = 1'b1;
      ST_T2: mem_en_d = 1'b1;
`ifdef WAIT_STATE_EN
      ST_TW: mem_en_d = 1'b1;
`endif
      ST_T3: mem_en_d = 1'b1;
      default: begin
        ale_d    = 1'b0;
        mem_en_d = 1'b0;
      end
    endcase
    mem_we_d = mem_en_d && (type_d == REQ_WRITE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      type_q     <= REQ_FETCH;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      rdata_q    <= {DATA_WIDTH{1'b0}};
      req_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ale_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      stat_q     <= STAT_IDLE;
      mem_addr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      req_ack_q  <= req_ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ale_q      <= ale_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      stat_q     <= stat_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // The data bus is only ever driven during the enabled phase of a write
  assign mem_data = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req_ack  = req_ack_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ale      = ale_q;
  assign s1       = stat_q[1];
  assign s0       = stat_q[0];
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl with a 32x8 RAM model on a pulled-up data bus.
module tb_bus_cycle_ctrl;

`ifdef WAIT_STATE_EN
  localparam int FETCH_WAITS = 2;
`else
  localparam int FETCH_WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req, ready;
  logic [1:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ack, done, busy, ale, s1, s0, mem_en, mem_we;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  tri1  [7:0]  mem_data;

  logic [7:0]  ram [0:31];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          accept;
    int          waits;
  } xfer_t;

  xfer_t done_q[$];
  int    ack_q[$];

  always #5 clk = ~clk;

  bus_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .done(done), .rdata(rdata), .busy(busy),
    .ready(ready), .ale(ale), .s1(s1), .s0(s0), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  assign mem_data = (mem_en && !mem_we) ? ram[mem_addr[4:0]] : 8'hzz;

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      if (mem_en && mem_we) ram[mem_addr[4:0]] = mem_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input logic [1:0] k);
    case (k)
      2'b00:   return 2'b11;
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor: pops the scoreboard on ack/done and checks bus behaviour every cycle
  initial begin
    xfer_t      cur;
    int         a;
    int         en_cnt;
    int         we_cnt;
    logic [7:0] last_rdata;
    en_cnt = 0; we_cnt = 0; last_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt = 0; we_cnt = 0; last_rdata = 8'h00;
      end else begin
        if (req_ack) begin
          if (ack_q.size() == 0) check("spurious_ack", 32'(req_ack), 32'd0);
          else begin
            a = ack_q.pop_front();
            check("ack_edge", 32'(edge_cnt), 32'(a));
          end
        end
        if (done) begin
          if (done_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
          else begin
            cur = done_q.pop_front();
            check("done_latency", 32'(edge_cnt - cur.accept + 1), 32'(4 + cur.waits));
            check("en_cycles", 32'(en_cnt), 32'(2 + cur.waits));
            check("we_cycles", 32'(we_cnt), (cur.kind == 2'b10) ? 32'(2 + cur.waits) : 32'd0);
            if (cur.kind == 2'b10) check("rdata_held", 32'(rdata), 32'(last_rdata));
            else begin
              check("rdata", 32'(rdata), 32'(cur.exp_rdata));
              last_rdata = cur.exp_rdata;
            end
          end
          en_cnt = 0; we_cnt = 0;
        end
        if (busy) begin
          if (done_q.size() == 0) check("busy_without_xfer", 32'(busy), 32'd0);
          else begin
            cur = done_q[0];
            check("status", 32'({s1, s0}), 32'(code_of(cur.kind)));
            check("ale", 32'(ale), 32'(edge_cnt == cur.accept));
            check("mem_addr", 32'(mem_addr), 32'(cur.addr));
            if (mem_en) begin
              en_cnt = en_cnt + 1;
              if (mem_we) begin
                we_cnt = we_cnt + 1;
                check("write_data", 32'(mem_data), 32'(cur.wdata));
              end else begin
                check("read_bus_clean", 32'(mem_data), 32'(ram[mem_addr[4:0]]));
              end
            end else begin
              check("t1_bus_hiz", 32'(mem_data), 32'h000000ff);
            end
          end
        end else begin
          check("idle_ctrl", 32'({ale, s1, s0, mem_en, mem_we}), 32'd0);
          check("idle_addr", 32'(mem_addr), 32'd0);
          check("idle_bus_hiz", 32'(mem_data), 32'h000000ff);
        end
      end
    end
  end

  // Issue at a negedge; returns at the negedge inside T1
  task automatic issue(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input int waits);
    xfer_t x;
    x.kind = kind; x.addr = addr; x.wdata = wd; x.exp_rdata = exp_rd;
    x.accept = edge_cnt + 1; x.waits = waits;
    done_q.push_back(x);
    ack_q.push_back(x.accept);
    req = 1'b1; req_type = kind; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req = 1'b0; req_type = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    if (done_q.size() != 0) begin
      check("timeout", 32'(done_q.size()), 32'd0);
      done_q.delete();
      ack_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'h40 + 8'(i);
    rst_n = 1'b0; req = 1'b0; req_type = 2'b00; req_addr = 16'h0000;
    req_wdata = 8'h00; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({req_ack, done, busy, ale, s1, s0, mem_en, mem_we}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_bus_hiz", 32'(mem_data), 32'h000000ff);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b10, 16'h0003, 8'hA5, 8'h00, 0);
    wait_idle(20);
    check("ram3_written", 32'(ram[3]), 32'h000000a5);

    issue(2'b01, 16'h0003, 8'h00, 8'hA5, 0);
    wait_idle(20);

    // READY low across the T2 and first TW exit edges
    ready = 1'b0;
    issue(2'b00, 16'h1207, 8'h00, 8'h47, FETCH_WAITS);
    repeat (3) @(negedge clk);
    ready = 1'b1;
    wait_idle(20);

    // Back-to-back: write issued in the read's done cycle
    issue(2'b01, 16'h0003, 8'h00, 8'hA5, 0);
    repeat (3) @(negedge clk);
    issue(2'b10, 16'h0010, 8'h3C, 8'h00, 0);
    wait_idle(20);
    check("ram16_written", 32'(ram[16]), 32'h0000003c);
    issue(2'b01, 16'h0010, 8'h00, 8'h3C, 0);
    wait_idle(20);

    req = 1'b1; req_type = 2'b11; req_addr = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsvd_no_start", 32'({busy, req_ack}), 32'd0);
    end
    req = 1'b0; req_type = 2'b00;
    @(negedge clk);

    // Asynchronous reset in T2 of a write
    issue(2'b10, 16'h0005, 8'h5A, 8'h00, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    done_q.delete();
    ack_q.delete();
    #1;
    check("arst_outputs", 32'({req_ack, done, busy, ale, s1, s0, mem_en, mem_we}), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_rdata", 32'(rdata), 32'd0);
    check("arst_bus_hiz", 32'(mem_data), 32'h000000ff);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_reset", 32'(done), 32'd0);
    issue(2'b01, 16'h0003, 8'h00, 8'hA5, 0);
    wait_idle(20);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Bus cycle controller for the 8085 datapath. It converts single-transfer requests from the core (opcode fetch, memory read, memory write) into T1/T2/T3 machine cycles on the memory bus. It drives the address, the enable, the write strobe and the bidirectional data bus of the 32×8 RAM stage directly downstream. It returns read data and a completion pulse to the core.

## Interface
- data_width, 8, data bus width
- addr_width, 16, address bus width
- clk  input  1  rising-edge clock shared with memory
- rst_n  input  1  asynchronous active-low reset
- req  input  1  core transfer request; sampled only in IDLE
- req_type  input  2  00 fetch, 01 read, 10 write, 11 reserved (treated as no request)
- req_addr  input  addr_width  transfer address
- req_wdata  input  data_width  write data
- req_ack  output  1  one-cycle pulse: request accepted
- done  output  1  one-cycle pulse: transfer complete, rdata valid
- rdata  output  data_width  read/fetch data, held until next read completes
- busy  output  1  high in T1/T2/TW/T3
- ready  input  1  memory ready (8085 READY)
- ale  output  1  address latch enable, high in T1 only
- s1, s0  output  1 each  status: fetch 11, read 10, write 01, idle 00
- mem_en  output  1  memory enable
- mem_we  output  1  memory write strobe (memory writes on clk edge when mem_en && mem_we)
- mem_addr  output  addr_width  memory address
- mem_data  inout  data_width  memory data bus

## Operation
- States: IDLE, T1, T2, TW, T3.
- IDLE: if req && req_type!=11, latch type/addr/wdata, pulse req_ack, go to T1.
- T1: ale=1, mem_addr=latched addr, mem_en=0. Go to T2.
- T2: mem_en=1, mem_we=(type==write). If ready=0 at the edge, go to TW; otherwise go to T3.
- TW: same outputs as T2. Go to T3 on the first edge with ready=1.
- T3: same outputs as T2. At the exit edge, read/fetch captures mem_data into rdata. A write commits in memory on the same edge. Go to IDLE.
- done is registered and goes high in the IDLE cycle that follows T3, for one cycle.
- mem_data is driven with the latched wdata only in T2/TW/T3 of a write. Otherwise it is high-Z. The controller never drives mem_data while mem_en=1 and mem_we=0.
- mem_addr holds the latched address from T1 through T3. It is 0 in IDLE.
- s1/s0 hold the transfer code from T1 through T3. They are 00 in IDLE.
- A new request in the done cycle is accepted, giving back-to-back transfers.
- Reset (asynchronous, any state): state=IDLE. req_ack, done, busy, ale, mem_en, mem_we, s1, s0 = 0. mem_addr=0, rdata=0, mem_data high-Z. An interrupted write may or may not have committed. No done is issued for it.

## Timing
- Accept edge to done: 4 cycles with no wait states (T1, T2, T3, then done), plus one cycle per TW.
- Throughput: one transfer per 4 cycles.
- req_ack is asserted in the cycle after the accepting edge, i.e. during T1.
- ready is sampled only at the T2 and TW exit edges. It is ignored elsewhere.

## Configuration
- WAIT_STATE_EN defined: ready is honoured and TW is reachable.
- WAIT_STATE_EN undefined: ready is ignored, T2 always goes to T3, and the TW state is not compiled. The ready port remains present.

## Structure
- Package bus_pkg holds:
  - req_type encodings (FETCH, READ, WRITE)
  - state encoding (IDLE, T1, T2, TW, T3)
  - status codes for s1/s0
- Single module with no sub-module. The tristate driver is one continuous assignment.

## Test plan
- Reset, then write 8'hA5 to 16'h0003: req_ack during T1; mem_en=1 and mem_we=1 for 2 cycles; memory word 3 = A5; done 4 cycles after accept.
- Read 16'h0003 after the write: mem_data is not driven by the controller; rdata=A5 with done; s1/s0=10 during T1–T3.
- Fetch with ready low for 2 cycles (WAIT_STATE_EN): exactly 2 TW cycles; done 6 cycles after accept; s1/s0=11.
- Back-to-back: read then write issued in the done cycle: second req_ack follows immediately; no idle gap; no bus contention (mem_data never driven by both sides).
- req_type=11 while idle: no req_ack, busy stays 0, bus stays idle.
- rst_n low during T2 of a write: all outputs go to reset values asynchronously; mem_data high-Z; no done; a subsequent read completes normally.
